// File: rtl/mcu_block_scheduler.sv
// Walks Y_BLOCKS luma blocks then one U and one V block per MCU, draining each
// matrix buffer as one uninterrupted burst into the shared dequantise/IDCT engine.
module mcu_block_scheduler #(
  parameter int DATA_W   = 16,
  parameter int MCU_SIZE = 64,
  parameter int PX_OUT   = 1,
  parameter int PY_OUT   = 1,
  parameter int Y_BLOCKS = 4
) (
  input  logic                            i_sysclk,
  input  logic                            i_srst,
  input  logic                            i_Y_nempty,
  input  logic                            i_U_nempty,
  input  logic                            i_V_nempty,
  output logic                            o_Y_re,
  output logic                            o_U_re,
  output logic                            o_V_re,
  input  logic [PY_OUT*PX_OUT*DATA_W-1:0] i_Y_md,
  input  logic [PY_OUT*PX_OUT*DATA_W-1:0] i_U_md,
  input  logic [PY_OUT*PX_OUT*DATA_W-1:0] i_V_md,
  input  logic                            i_idct_ready,
  output logic                            o_idct_de,
  output logic [PY_OUT*PX_OUT*DATA_W-1:0] o_idct_B,
  output logic [1:0]                      o_idct_ch,
  output logic                            o_idct_sob,
  output logic                            o_idct_eob,
  output logic                            o_mcu_done,
  output logic                            o_busy
);

  localparam int BEATS = MCU_SIZE / (PX_OUT * PY_OUT);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = $clog2(Y_BLOCKS + 2);

  localparam logic [1:0] S_SEL    = 2'd0;
  localparam logic [1:0] S_RD     = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam logic [1:0] CH_Y = 2'd0;
  localparam logic [1:0] CH_U = 2'd1;
  localparam logic [1:0] CH_V = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0] PTR_U     = PTR_W'(Y_BLOCKS);
  localparam logic [PTR_W-1:0] PTR_V     = PTR_W'(Y_BLOCKS + 1);

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] beat;
  logic [1:0]       cur_ch;
  logic             cur_nempty;
  logic             rd;
  logic             grant;
  logic             last_beat;

  logic             vld_p1;
  logic [1:0]       ch_p1;
  logic             sob_p1;
  logic             eob_p1;
  logic             done_p1;

  // Pointer slots 0..Y_BLOCKS-1 are luma; the last two are U then V.
  always_comb begin
    cur_ch     = CH_Y;
    cur_nempty = i_Y_nempty;
    if (ptr == PTR_U) begin
      cur_ch     = CH_U;
      cur_nempty = i_U_nempty;
    end else if (ptr == PTR_V) begin
      cur_ch     = CH_V;
      cur_nempty = i_V_nempty;
    end
  end

  assign rd        = (state == S_RD);
  assign grant     = (state == S_SEL) && cur_nempty && i_idct_ready;
  assign last_beat = rd && (beat == LAST_BEAT);

  // Reset must stop the buffer pops in the very cycle it is raised.
  assign o_Y_re = rd && !i_srst && (cur_ch == CH_Y);
  assign o_U_re = rd && !i_srst && (cur_ch == CH_U);
  assign o_V_re = rd && !i_srst && (cur_ch == CH_V);

  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      state <= S_SEL;
      ptr   <= '0;
      beat  <= '0;
    end else begin
      case (state)
        S_SEL: begin
          if (grant) begin
            state <= S_RD;
            beat  <= '0;
          end
        end
        S_RD: begin
          beat <= beat + 1'b1;
          if (beat == LAST_BEAT) begin
            state <= S_SETTLE;
            beat  <= '0;
            ptr   <= (ptr == PTR_V) ? '0 : ptr + 1'b1;
          end
        end
        default: state <= S_SEL;
      endcase
    end
  end

  // Stage p1: aligns the beat tags with buffer read data, which lags re by one cycle.
  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      vld_p1  <= 1'b0;
      ch_p1   <= CH_Y;
      sob_p1  <= 1'b0;
      eob_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= rd;
      ch_p1   <= rd ? cur_ch : ch_p1;
      sob_p1  <= rd && (beat == '0);
      eob_p1  <= last_beat;
      done_p1 <= last_beat && (cur_ch == CH_V);
    end
  end

  always_comb begin
    o_idct_B = '0;
    if (vld_p1) begin
      case (ch_p1)
        CH_U:    o_idct_B = i_U_md;
        CH_V:    o_idct_B = i_V_md;
        default: o_idct_B = i_Y_md;
      endcase
    end
  end

  assign o_idct_de  = vld_p1;
  assign o_idct_ch  = ch_p1;
  assign o_idct_sob = sob_p1;
  assign o_idct_eob = eob_p1;
  assign o_mcu_done = done_p1;
  assign o_busy     = rd || (state == S_SETTLE) || vld_p1;

endmodule

// File: tb/tb_mcu_block_scheduler.sv
// Bench for mcu_block_scheduler: a 4:2:0 instance (64 beats) and a Y_BLOCKS=1,
// 2x2-beat instance (16 beats), scored against a block-level MCU order model.
module tb_mcu_block_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus: index 0 = 4:2:0 / 64 beats, index 1 = Y_BLOCKS=1 / 16 beats
  logic       srst [2];
  logic [2:0] ne   [2];   // {V,U,Y}
  logic       rdy  [2];

  logic [15:0] md_a [3];
  logic [63:0] md_b [3];

  wire        a_yre, a_ure, a_vre, a_de, a_sob, a_eob, a_done, a_busy;
  wire [1:0]  a_ch;
  wire [15:0] a_b;
  wire        b_yre, b_ure, b_vre, b_de, b_sob, b_eob, b_done, b_busy;
  wire [1:0]  b_ch;
  wire [63:0] b_b;

  mcu_block_scheduler #(.DATA_W(16), .MCU_SIZE(64), .PX_OUT(1), .PY_OUT(1), .Y_BLOCKS(4)) dut_a (
    .i_sysclk(clk), .i_srst(srst[0]),
    .i_Y_nempty(ne[0][0]), .i_U_nempty(ne[0][1]), .i_V_nempty(ne[0][2]),
    .o_Y_re(a_yre), .o_U_re(a_ure), .o_V_re(a_vre),
    .i_Y_md(md_a[0]), .i_U_md(md_a[1]), .i_V_md(md_a[2]),
    .i_idct_ready(rdy[0]), .o_idct_de(a_de), .o_idct_B(a_b), .o_idct_ch(a_ch),
    .o_idct_sob(a_sob), .o_idct_eob(a_eob), .o_mcu_done(a_done), .o_busy(a_busy)
  );

  mcu_block_scheduler #(.DATA_W(16), .MCU_SIZE(64), .PX_OUT(2), .PY_OUT(2), .Y_BLOCKS(1)) dut_b (
    .i_sysclk(clk), .i_srst(srst[1]),
    .i_Y_nempty(ne[1][0]), .i_U_nempty(ne[1][1]), .i_V_nempty(ne[1][2]),
    .o_Y_re(b_yre), .o_U_re(b_ure), .o_V_re(b_vre),
    .i_Y_md(md_b[0]), .i_U_md(md_b[1]), .i_V_md(md_b[2]),
    .i_idct_ready(rdy[1]), .o_idct_de(b_de), .o_idct_B(b_b), .o_idct_ch(b_ch),
    .o_idct_sob(b_sob), .o_idct_eob(b_eob), .o_mcu_done(b_done), .o_busy(b_busy)
  );

  logic [2:0]  re   [2];
  logic        de   [2];
  logic        sob  [2];
  logic        eob  [2];
  logic        done [2];
  logic        busy [2];
  logic [1:0]  ch   [2];
  logic [63:0] bus  [2];

  always_comb begin
    re[0]   = {a_vre, a_ure, a_yre};  re[1]   = {b_vre, b_ure, b_yre};
    de[0]   = a_de;                   de[1]   = b_de;
    sob[0]  = a_sob;                  sob[1]  = b_sob;
    eob[0]  = a_eob;                  eob[1]  = b_eob;
    done[0] = a_done;                 done[1] = b_done;
    busy[0] = a_busy;                 busy[1] = b_busy;
    ch[0]   = a_ch;                   ch[1]   = b_ch;
    bus[0]  = {48'd0, a_b};           bus[1]  = b_b;
  end

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

  function automatic int beats_of(int k);
    return (k == 0) ? 64 : 16;
  endfunction

  function automatic int yb_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Channel of the idx-th block within an MCU: Y_BLOCKS lumas, then U, then V
  function automatic logic [1:0] exp_ch(int idx, int yb);
    if (idx < yb) return 2'd0;
    return 2'(idx - yb + 1);
  endfunction

  task automatic check(string name, int k, logic [79:0] got, logic [79:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s[inst%0d] at cycle %0d: got %h expected %h", name, k, cyc, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer models: each pop returns channel*1000 + beat index one cycle later
  int bcnt [2][3];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (srst[k]) begin
          bcnt[k][c] = 0;
        end else if (re[k][c]) begin
          if (k == 0) md_a[c] = 16'(c * 1000 + bcnt[k][c]);
          else        md_b[c] = {4{16'(c * 1000 + bcnt[k][c])}};
          bcnt[k][c] = (bcnt[k][c] + 1) % beats_of(k);
        end
      end
    end
  end

  // Block-level scoreboard
  logic       mon_en   [2] = '{1'b0, 1'b0};
  logic       rst_seen [2] = '{1'b1, 1'b1};
  logic [2:0] prev_ne  [2] = '{3'd0, 3'd0};
  logic       prev_rdy [2] = '{1'b0, 1'b0};
  logic [2:0] prev_re  [2] = '{3'd0, 3'd0};
  int mseq [2]      = '{0, 0};
  int mbeat [2]     = '{0, 0};
  int mblocks [2]   = '{0, 0};
  int done_n [2]    = '{0, 0};
  int done_last [2] = '{0, 0};
  int done_prev [2] = '{0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mon_en[k]) begin
        if (rst_seen[k]) begin
          check("reset_outputs", k,
                {bus[k], ch[k], de[k], sob[k], eob[k], done[k], busy[k], re[k]}, '0);
          mseq[k]  = 0;
          mbeat[k] = 0;
        end else begin
          if (de[k]) begin
            logic [1:0]  ec;
            logic [63:0] eb;
            logic        lst;
            int          v;
            ec  = exp_ch(mseq[k], yb_of(k));
            v   = int'(ec) * 1000 + mbeat[k];
            eb  = (k == 0) ? {48'd0, 16'(v)} : {4{16'(v)}};
            lst = (mbeat[k] == beats_of(k) - 1);
            check("beat", k, {bus[k], ch[k], sob[k], eob[k], done[k], busy[k]},
                  {eb, ec, (mbeat[k] == 0), lst, (lst && ec == 2'd2), 1'b1});
            if (lst) begin
              mbeat[k] = 0;
              mseq[k]  = (mseq[k] + 1) % (yb_of(k) + 2);
              mblocks[k]++;
            end else begin
              mbeat[k]++;
            end
          end else begin
            check("idle_or_gap", k, {bus[k], sob[k], eob[k], done[k], (mbeat[k] != 0)}, '0);
          end
          if (re[k] != 3'd0 && prev_re[k] == 3'd0) begin
            logic [1:0] gc;
            gc = exp_ch(mseq[k], yb_of(k));
            check("grant", k, {re[k], prev_ne[k][gc], prev_rdy[k]}, {3'b001 << gc, 1'b1, 1'b1});
          end
          if (re[k] != 3'd0) check("re_onehot", k, {31'd0, $onehot(re[k])}, 1);
        end
        if (srst[k]) check("re_gated_by_reset", k, re[k], 0);
        if (done[k]) begin
          done_n[k]++;
          done_prev[k] = done_last[k];
          done_last[k] = cyc;
        end
        rst_seen[k] = srst[k];
        prev_ne[k]  = ne[k];
        prev_rdy[k] = rdy[k];
        prev_re[k]  = re[k];
      end
    end
  end

  typedef struct {
    logic [2:0] ne;
    logic       rdy;
    logic [2:0] exp_re;
  } vec_t;
  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(int k, logic [2:0] n, logic r);
    tick();
    srst[k] = 1'b1;
    ne[k]   = n;
    rdy[k]  = r;
    tick();
    srst[k] = 1'b0;
  endtask

  initial begin
    int d0, dn, b0, dc, i;
    logic anyre;

    vecs[0] = '{ne: 3'b110, rdy: 1'b1, exp_re: 3'b000};
    vecs[1] = '{ne: 3'b111, rdy: 1'b0, exp_re: 3'b000};
    vecs[2] = '{ne: 3'b001, rdy: 1'b1, exp_re: 3'b001};
    vecs[3] = '{ne: 3'b000, rdy: 1'b1, exp_re: 3'b000};
    vecs[4] = '{ne: 3'b111, rdy: 1'b1, exp_re: 3'b001};
    vecs[5] = '{ne: 3'b011, rdy: 1'b1, exp_re: 3'b001};
    vecs[6] = '{ne: 3'b100, rdy: 1'b1, exp_re: 3'b000};

    for (int k = 0; k < 2; k++) begin
      srst[k] = 1'b1;
      ne[k]   = 3'd0;
      rdy[k]  = 1'b0;
    end
    tick();
    tick();
    mon_en[0] = 1'b1;
    mon_en[1] = 1'b1;
    @(negedge clk);
    check("reset_state", 0, {a_b, a_ch, a_de, a_sob, a_eob, a_done, a_busy, a_yre, a_ure, a_vre}, '0);

    // Grant decision from a fresh reset (pointer at Y0)
    for (int v = 0; v < 7; v++) begin
      restart(0, vecs[v].ne, vecs[v].rdy);
      tick();
      @(negedge clk);
      check("grant_vector", 0, re[0], vecs[v].exp_re);
    end

    // Full MCUs with everything available: order and period
    restart(0, 3'b111, 1'b1);
    d0 = done_n[0];
    for (i = 0; i < 1200 && done_n[0] < d0 + 2; i++) tick();
    check("mcu_done_seen", 0, (done_n[0] >= d0 + 2), 1);
    check("mcu_period_420", 0, done_last[0] - done_prev[0], 396);

    // Y empty holds off U and V
    restart(0, 3'b110, 1'b1);
    anyre = 1'b0;
    repeat (100) begin
      tick();
      anyre = anyre | (|re[0]);
    end
    check("no_re_while_y_empty", 0, anyre, 0);
    ne[0] = 3'b111;
    tick();
    @(negedge clk);
    check("y_re_after_nempty", 0, re[0], 3'b001);

    // Ready low blocks the grant; dropping it mid-block does not truncate
    restart(0, 3'b111, 1'b0);
    anyre = 1'b0;
    repeat (20) begin
      tick();
      anyre = anyre | (|re[0]);
    end
    check("no_re_while_not_ready", 0, anyre, 0);
    rdy[0] = 1'b1;
    tick();
    @(negedge clk);
    check("re_after_ready", 0, re[0], 3'b001);
    dc = 0;
    for (int j = 0; j < 90; j++) begin
      tick();
      dc += int'(de[0]);
      if (j == 9) rdy[0] = 1'b0;
    end
    check("beats_after_ready_drop", 0, dc, 64);

    // Reset in the middle of the U block
    restart(0, 3'b111, 1'b1);
    for (i = 0; i < 1000 && !re[0][1]; i++) tick();
    check("u_block_reached", 0, re[0][1], 1);
    repeat (30) tick();
    srst[0] = 1'b1;
    @(negedge clk);
    check("u_re_low_in_reset", 0, re[0], 0);
    tick();
    srst[0] = 1'b0;
    @(negedge clk);
    check("outputs_zero_after_reset", 0,
          {a_b, a_ch, a_de, a_sob, a_eob, a_done, a_busy, a_yre, a_ure, a_vre}, '0);
    for (i = 0; i < 10 && re[0] == 3'd0; i++) tick();
    check("first_grant_after_reset_is_y", 0, re[0], 3'b001);

    // Reset on the last V beat: no MCU completion
    restart(0, 3'b111, 1'b1);
    for (i = 0; i < 1000 && !re[0][2]; i++) tick();
    check("v_block_reached", 0, re[0][2], 1);
    repeat (63) tick();
    srst[0] = 1'b1;
    dn = done_n[0];
    @(negedge clk);
    check("v_re_low_in_reset", 0, re[0], 0);
    tick();
    srst[0] = 1'b0;
    repeat (3) tick();
    check("no_mcu_done_on_abort", 0, done_n[0], dn);

    // Randomised availability, back-pressure and occasional resets
    restart(0, 3'b000, 1'b0);
    b0 = mblocks[0];
    for (int j = 0; j < 4000; j++) begin
      tick();
      ne[0]   = 3'($urandom);
      rdy[0]  = ($urandom % 4) != 0;
      srst[0] = ($urandom % 700) == 0;
    end
    tick();
    srst[0] = 1'b0;
    check("random_progress", 0, ((mblocks[0] - b0) > 10), 1);

    // Y_BLOCKS=1, 16 beats per block
    ne[1]  = 3'b111;
    rdy[1] = 1'b1;
    tick();
    srst[1] = 1'b0;
    b0 = mblocks[1];
    for (i = 0; i < 400 && done_n[1] < 3; i++) tick();
    check("b_mcu_done_seen", 1, (done_n[1] >= 3), 1);
    check("b_mcu_period_54", 1, done_last[1] - done_prev[1], 54);
    check("b_blocks_per_3_mcu", 1, ((mblocks[1] - b0) >= 9), 1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
